alarm_wake_ctrl: RTL and testbench



---
 rtl/alarm_wake_ctrl.sv | 102 ++++++++++
 tb/tb_alarm_wake_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_wake_ctrl.sv
// alarm_wake_ctrl: alarm sequencer turning dismiss presses into CE/count_stop handshakes, with snooze and optional ring timeout
// Ports: clk/reset (sync, active-high); tick_1hz, alarm_en, alarm_match, dismiss_btn, snooze_btn, cnt_thresh in;
// cnt_ce/cnt_stop/cnt_clr counter handshake, buzzer, snooze_active, snooze_left, missed, state (debug) out.
// Define WAKE_TIMEOUT_EN to enable the ring timer; otherwise missed is constant 0.
module alarm_wake_ctrl #(
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       alarm_match,
  input  logic       dismiss_btn,
  input  logic       snooze_btn,
  input  logic       cnt_thresh,
  output logic       cnt_ce,
  output logic       cnt_stop,
  output logic       cnt_clr,
  output logic       buzzer,
  output logic       snooze_active,
  output logic [1:0] snooze_left,
  output logic       missed,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, RING = 3'd1, PRESS = 3'd2, REARM = 3'd3, SNOOZE = 3'd4, DONE = 3'd5} state_t;
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  state_t cur, nxt;
  logic clr_n, snz_dec, entry, timeout, hit;
  logic [SW-1:0] snz_cnt;
  assign state = cur;
  assign entry = cur == IDLE && nxt == RING;
  // thresh is stale while the counter is being cleared, so ignore it then
  assign hit = cnt_thresh && !cnt_clr;
  always_comb begin
    nxt = cur;
    clr_n = 1'b0;
    snz_dec = 1'b0;
    if (cur != IDLE && !alarm_en) begin
      nxt = IDLE;
      clr_n = 1'b1;
    end else case (cur)
      IDLE: if (alarm_en && alarm_match) begin
        nxt = RING;
        clr_n = 1'b1;
      end
      RING: if (hit || timeout) nxt = DONE;
      else if (dismiss_btn) nxt = PRESS;
      else if (snooze_btn && snooze_left != 2'd0) begin
        nxt = SNOOZE;
        clr_n = 1'b1;
        snz_dec = 1'b1;
      end
      PRESS: nxt = REARM;
      REARM: nxt = RING;
      SNOOZE: if (tick_1hz && snz_cnt == SW'(SNOOZE_SEC - 1)) nxt = RING;
      DONE: if (!alarm_match) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      cnt_ce <= 1'b0;
      cnt_stop <= 1'b0;
      cnt_clr <= 1'b1;
      buzzer <= 1'b0;
      snooze_active <= 1'b0;
      snooze_left <= 2'(MAX_SNOOZE);
      snz_cnt <= '0;
    end else begin
      cur <= nxt;
      cnt_ce <= nxt == PRESS;
      cnt_stop <= nxt == REARM;
      cnt_clr <= clr_n;
      buzzer <= nxt inside {RING, PRESS, REARM};
      snooze_active <= nxt == SNOOZE;
      snooze_left <= entry ? 2'(MAX_SNOOZE) : snz_dec ? snooze_left - 2'd1 : snooze_left;
      snz_cnt <= snz_dec ? '0 : cur == SNOOZE && tick_1hz && snz_cnt != SW'(SNOOZE_SEC) ? snz_cnt + SW'(1) : snz_cnt;
    end
  end
`ifdef WAKE_TIMEOUT_EN
  localparam int RW = $clog2(RING_TIMEOUT + 1);
  logic [RW-1:0] ring_cnt;
  // a timeout reached in PRESS/REARM leaves the timer saturated and fires on return to RING
  assign timeout = ring_cnt == RW'(RING_TIMEOUT) || (tick_1hz && ring_cnt == RW'(RING_TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_cnt <= '0;
      missed <= 1'b0;
    end else begin
      ring_cnt <= entry || (cur == SNOOZE && nxt == RING) ? '0 :
                  tick_1hz && cur inside {RING, PRESS, REARM} && ring_cnt != RW'(RING_TIMEOUT) ? ring_cnt + RW'(1) : ring_cnt;
      missed <= entry ? 1'b0 : cur == RING && nxt == DONE && !hit ? 1'b1 : missed;
    end
  end
`else
  assign timeout = 1'b0;
  assign missed = RING_TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_alarm_wake_ctrl.sv
// tb_alarm_wake_ctrl: scoreboard bench for alarm_wake_ctrl with a 0-9 dismiss counter model
module tb_alarm_wake_ctrl;
  localparam int ST = 0, BUZ = 1, CE = 2, STOP = 3, CLR = 4, SACT = 5, SL = 6, MIS = 7, CEN = 8, STN = 9;
`ifdef WAKE_TIMEOUT_EN
  localparam int TO = 1;
`else
  localparam int TO = 0;
`endif
  logic clk = 0, reset = 1, tick_1hz = 0, alarm_en = 0, alarm_match = 0, dismiss_btn = 0, snooze_btn = 0;
  logic cnt_thresh, cnt_ce, cnt_stop, cnt_clr, buzzer, snooze_active, missed;
  logic [1:0] snooze_left;
  logic [2:0] state;
  int cnt = 0, cyc = 0, ce_n = 0, stop_n = 0, checks = 0, failures = 0;
  typedef struct {int cyc; int sel; int exp; string tag;} exp_t;
  exp_t q[$];
  alarm_wake_ctrl #(.SNOOZE_SEC(4), .MAX_SNOOZE(2), .RING_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .alarm_en(alarm_en), .alarm_match(alarm_match),
    .dismiss_btn(dismiss_btn), .snooze_btn(snooze_btn), .cnt_thresh(cnt_thresh), .cnt_ce(cnt_ce),
    .cnt_stop(cnt_stop), .cnt_clr(cnt_clr), .buzzer(buzzer), .snooze_active(snooze_active),
    .snooze_left(snooze_left), .missed(missed), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt_clr ? 0 : (cnt_ce && cnt < 9) ? cnt + 1 : cnt;
  assign cnt_thresh = cnt == 9;
  function automatic int obs(int sel);
    case (sel)
      ST: return int'(state);
      BUZ: return int'(buzzer);
      CE: return int'(cnt_ce);
      STOP: return int'(cnt_stop);
      CLR: return int'(cnt_clr);
      SACT: return int'(snooze_active);
      SL: return int'(snooze_left);
      MIS: return int'(missed);
      CEN: return ce_n;
      default: return stop_n;
    endcase
  endfunction
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic push(int dc, int sel, int exp, string tag);
    q.push_back('{cyc + dc, sel, exp, tag});
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      ce_n += int'(cnt_ce);
      stop_n += int'(cnt_stop);
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].cyc <= cyc) begin
          check(q[i].tag, q[i].cyc == cyc ? obs(q[i].sel) : -1, q[i].exp);
          q.delete(i);
        end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  initial begin
    int ce0, st0;
    @(posedge clk);
    #1;
    push(0, ST, 0, "rst_state"); push(0, CLR, 1, "rst_clr"); push(0, BUZ, 0, "rst_buzzer");
    push(0, SL, 2, "rst_sleft"); push(0, MIS, 0, "rst_missed"); push(0, SACT, 0, "rst_sact"); push(0, CE, 0, "rst_ce");
    step(1);
    reset = 0;
    push(1, CLR, 0, "rst_clr_drop"); push(1, ST, 0, "idle_hold");
    step(2);
    alarm_en = 1; alarm_match = 1;
    push(1, ST, 1, "ring_entry"); push(1, BUZ, 1, "ring_buzzer"); push(1, CLR, 1, "entry_clr");
    push(1, SL, 2, "entry_sleft"); push(2, CLR, 0, "entry_clr_end");
    step(1);
    ce0 = ce_n; st0 = stop_n;
    for (int k = 0; k < 9; k++) begin
      dismiss_btn = 1;
      push(1, ST, 2, "press_state"); push(1, CE, 1, "press_ce"); push(2, STOP, 1, "rearm_stop");
      push(2, CE, 0, "ce_one_cycle"); push(3, ST, 1, "back_ring");
      if (k == 8) begin
        push(4, ST, 5, "done_state"); push(4, BUZ, 0, "done_buzzer");
      end
      step(1);
      dismiss_btn = 0;
      step(4);
    end
    push(0, CEN, ce0 + 9, "ce_pulses"); push(0, STN, st0 + 9, "stop_pulses"); push(3, ST, 5, "done_hold");
    step(4);
    alarm_match = 0;
    push(1, ST, 0, "done_idle");
    step(2);
    alarm_match = 1;
    push(1, ST, 1, "b_ring"); push(1, SL, 2, "b_sleft");
    step(2);
    dismiss_btn = 1; snooze_btn = 1;
    push(1, ST, 2, "both_press"); push(1, SL, 2, "both_sleft"); push(1, SACT, 0, "both_sact");
    step(1);
    dismiss_btn = 0; snooze_btn = 0;
    step(3);
    ce0 = ce_n;
    dismiss_btn = 1;
    push(1, ST, 2, "gap_press"); push(2, ST, 3, "gap_rearm"); push(3, ST, 1, "gap_ring");
    push(4, ST, 1, "drop_ring"); push(4, CE, 0, "drop_no_ce");
    step(1);
    dismiss_btn = 0;
    step(1);
    dismiss_btn = 1;
    step(1);
    dismiss_btn = 0;
    step(3);
    push(0, CEN, ce0 + 1, "drop_ce_count");
    for (int s = 0; s < 3; s++) begin
      snooze_btn = 1;
      if (s < 2) begin
        push(1, ST, 4, "snz_state"); push(1, SACT, 1, "snz_active"); push(1, BUZ, 0, "snz_buzzer");
        push(1, SL, 1 - s, "snz_sleft"); push(1, CLR, 1, "snz_clr"); push(2, CLR, 0, "snz_clr_end");
        step(1);
        snooze_btn = 0;
        dismiss_btn = 1;
        push(1, ST, 4, "snz_ign_dismiss");
        step(1);
        dismiss_btn = 0;
        snooze_btn = 1;
        push(1, ST, 4, "snz_ign_snooze"); push(1, SL, 1 - s, "snz_sleft_hold");
        step(1);
        snooze_btn = 0;
        for (int t = 0; t < 4; t++) begin
          tick_1hz = 1;
          push(1, ST, t == 3 ? 1 : 4, "snz_tick_state");
          if (t == 3) begin
            push(1, BUZ, 1, "snz_end_buzzer"); push(1, SACT, 0, "snz_end_sact");
          end
          step(1);
          tick_1hz = 0;
          step(2);
        end
      end else begin
        push(1, ST, 1, "snz_ignored"); push(1, BUZ, 1, "snz_ign_buzzer"); push(1, SL, 0, "snz_ign_sleft");
        push(1, CLR, 0, "snz_ign_clr"); push(1, SACT, 0, "snz_ign_sact");
        step(1);
        snooze_btn = 0;
        step(2);
      end
    end
    dismiss_btn = 1;
    push(1, ST, 2, "dis_press");
    step(1);
    dismiss_btn = 0; alarm_en = 0;
    push(1, ST, 0, "dis_idle"); push(1, CLR, 1, "dis_clr"); push(1, BUZ, 0, "dis_buzzer");
    push(1, STOP, 0, "dis_no_stop"); push(2, CLR, 0, "dis_clr_end");
    step(3);
    alarm_en = 1;
    push(1, ST, 1, "to_ring"); push(1, MIS, 0, "to_missed_init");
    step(2);
    for (int t = 0; t < 8; t++) begin
      tick_1hz = 1;
      push(1, ST, (t == 7 && TO == 1) ? 5 : 1, "to_state");
      step(1);
      tick_1hz = 0;
      step(2);
    end
    push(0, MIS, TO, "to_missed"); push(0, BUZ, 1 - TO, "to_buzzer");
    alarm_match = 0;
    push(1, ST, TO == 1 ? 0 : 1, "to_match_low"); push(1, MIS, TO, "missed_hold");
    step(2);
    alarm_match = 1;
    push(1, ST, 1, "re_ring"); push(1, MIS, 0, "missed_clr");
    step(2);
    alarm_en = 0;
    push(1, ST, 0, "end_idle"); push(1, CLR, 1, "end_clr");
    step(2);
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
    check("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
